// File: rtl/status_wr_engine_pkg.sv
// status_wr_engine_pkg: shared types, mdata tags and the status line builder for the status write path
package status_wr_engine_pkg;
  localparam int CL_ADDR_W = 42;
  localparam int CL_DATA_W = 512;
  typedef logic [CL_ADDR_W-1:0] t_cci_cl_addr;
  typedef logic [CL_DATA_W-1:0] t_cci_cl_data;
  typedef logic [31:0] t_uint32;
  localparam logic [15:0] READ_CTRL_MDATA = 16'd1;
  localparam logic [15:0] READ_RUN_MDATA = 16'd2;
  localparam logic [15:0] WRITE_STATUS_MDATA = 16'd7;
  typedef enum logic [2:0] {
    STATUS_IDLE = 3'd0,
    STATUS_RUNNING = 3'd1,
    STATUS_ERROR = 3'd2,
    STATUS_DONE = 3'd3
  } e_status_code;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } e_status_wr_state;
  // Status line: u64[0]=code, u64[1]=cls_sent, nonce in the top byte of u64[7], all else zero
  function automatic t_cci_cl_data construct_status_cl_seq(e_status_code code, t_uint32 cls_sent, logic [7:0] seq);
    t_cci_cl_data cl;
    cl = '0;
    cl[63:0] = {61'd0, code};
    cl[127:64] = {32'd0, cls_sent};
    cl[511:504] = seq;
    return cl;
  endfunction
endpackage

// File: rtl/status_wr_engine_if.sv
// status_wr_engine_if: request, c1 write and write-response signals of the status write engine
interface status_wr_engine_if;
  import status_wr_engine_pkg::*;
  t_cci_cl_addr status_addr;
  logic req_valid;
  logic req_ready;
  e_status_code req_code;
  t_uint32 req_cls_sent;
  logic c1_alm_full;
  logic wr_valid;
  t_cci_cl_addr wr_addr;
  t_cci_cl_data wr_data;
  logic [15:0] wr_mdata;
  logic wr_rsp_valid;
  logic [15:0] wr_rsp_mdata;
  logic done;
  logic error;
  modport master (
    output status_addr, req_valid, req_code, req_cls_sent, c1_alm_full, wr_rsp_valid, wr_rsp_mdata,
    input req_ready, wr_valid, wr_addr, wr_data, wr_mdata, done, error
  );
  modport slave (
    input status_addr, req_valid, req_code, req_cls_sent, c1_alm_full, wr_rsp_valid, wr_rsp_mdata,
    output req_ready, wr_valid, wr_addr, wr_data, wr_mdata, done, error
  );
endinterface

// File: rtl/status_wr_engine.sv
// status_wr_engine: writes a nonce-tagged status line to the CPU status buffer over c1 and reports completion
module status_wr_engine
  import status_wr_engine_pkg::*;
#(
  parameter int RSP_TIMEOUT = 1024
) (
  input logic clk,
  input logic reset,
  status_wr_engine_if.slave bus
);
  localparam int TW = $clog2(RSP_TIMEOUT);
  e_status_wr_state state, state_nx;
  logic [TW-1:0] timer;
  logic retry, done_q, error_q, accept, rsp_hit, tmo;
  logic [7:0] seq, seq_q;
  e_status_code code_q;
  t_uint32 cls_q;
  t_cci_cl_addr addr_q;
  assign rsp_hit = state == WAIT_RSP && bus.wr_rsp_valid && bus.wr_rsp_mdata == WRITE_STATUS_MDATA;
  assign tmo = state == WAIT_RSP && !rsp_hit && timer == TW'(RSP_TIMEOUT - 1);
  assign bus.req_ready = state == IDLE && !done_q && !reset;
  assign accept = bus.req_valid && bus.req_ready;
  assign bus.wr_valid = state == ISSUE && !bus.c1_alm_full;
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = construct_status_cl_seq(code_q, cls_q, seq_q);
  assign bus.wr_mdata = WRITE_STATUS_MDATA;
  assign bus.done = done_q;
  assign bus.error = error_q;
  // Next state: IDLE accepts, ISSUE waits out back-pressure, WAIT_RSP resolves to done, one reissue, or give-up
  always_comb begin
    state_nx = state;
    if (state == IDLE && accept) state_nx = ISSUE;
    if (state == ISSUE && !bus.c1_alm_full) state_nx = WAIT_RSP;
    if (rsp_hit || (tmo && retry)) state_nx = IDLE;
    else if (tmo) state_nx = ISSUE;
  end
  // State register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // Request latch, response timer, retry flag, nonce counter (skips 0) and done/error flags
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      timer <= '0;
      retry <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      seq <= 8'd1;
      seq_q <= '0;
      code_q <= STATUS_IDLE;
      cls_q <= '0;
      addr_q <= '0;
    end else begin
      timer <= state == WAIT_RSP ? timer + TW'(1) : '0;
      done_q <= rsp_hit;
      if (tmo) retry <= 1'b1;
      if (tmo && retry) error_q <= 1'b1;
      if (rsp_hit) seq <= seq == 8'd255 ? 8'd1 : seq + 8'd1;
      if (accept) begin
        code_q <= bus.req_code;
        cls_q <= bus.req_cls_sent;
        addr_q <= bus.status_addr;
        seq_q <= seq;
        retry <= 1'b0;
      end
    end
endmodule

// File: tb/tb_status_wr_engine.sv
// tb_status_wr_engine: table-driven, randomized and corner-case checks of status_wr_engine against a transaction model
module tb_status_wr_engine;
  import status_wr_engine_pkg::*;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int nvec = 0;
  int nmis = 0;
  int mseq = 1;
  bit merr = 1'b0;
  typedef struct {
    int code;
    logic [31:0] cls;
    logic [41:0] addr;
    int bp;
    int d1;
    int d2;
    int fk;
    int exp_seq;
    bit exp_err;
  } vec_t;
  vec_t tbl[7];
  status_wr_engine_if bus();
  status_wr_engine #(.RSP_TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic int next_seq(int s);
    return (s % 255) + 1;
  endfunction
  task automatic chk1(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask
  task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input vec_t v);
    logic [63:0] u[8];
    logic [511:0] exp_cl;
    int d;
    for (int j = 0; j < 8; j++) u[j] = '0;
    u[0] = 64'(v.code);
    u[1] = {32'd0, v.cls};
    u[7] = {v.exp_seq[7:0], 56'd0};
    for (int j = 0; j < 8; j++) exp_cl[j*64 +: 64] = u[j];
    cyc();
    bus.req_valid = 1'b1;
    bus.req_code = e_status_code'(v.code);
    bus.req_cls_sent = v.cls;
    bus.status_addr = v.addr;
    bus.c1_alm_full = v.bp > 0;
    #1;
    chk1("req_ready_idle", bus.req_ready, 1'b1);
    chk1("wr_valid_idle", bus.wr_valid, 1'b0);
    cyc();
    bus.req_valid = 1'b0;
    bus.req_code = e_status_code'($urandom_range(0, 3));
    bus.req_cls_sent = $urandom;
    bus.status_addr = 42'({$urandom, $urandom});
    for (int a = 0; a < 2; a++) begin
      for (int i = 0; i < (a == 0 ? v.bp : 0); i++) begin
        bus.c1_alm_full = 1'b1;
        bus.wr_rsp_valid = i == 0;
        bus.wr_rsp_mdata = WRITE_STATUS_MDATA;
        #1;
        chk1("wr_valid_backpressure", bus.wr_valid, 1'b0);
        chk1("done_stale_in_issue", bus.done, 1'b0);
        cyc();
      end
      bus.c1_alm_full = 1'b0;
      bus.wr_rsp_valid = 1'b0;
      #1;
      chk1("wr_valid", bus.wr_valid, 1'b1);
      chk1("done_at_issue", bus.done, 1'b0);
      chkw("wr_addr", 512'(bus.wr_addr), 512'(v.addr));
      chkw("wr_data", bus.wr_data, exp_cl);
      chkw("wr_mdata", 512'(bus.wr_mdata), 512'(16'd7));
      d = a == 0 ? v.d1 : v.d2;
      for (int k = 0; k < TMO; k++) begin
        cyc();
        bus.wr_rsp_valid = (k == d) || (k == v.fk);
        bus.wr_rsp_mdata = k == d ? 16'd7 : 16'd5;
        #1;
        chk1("wr_valid_wait", bus.wr_valid, 1'b0);
        chk1("done_wait", bus.done, 1'b0);
        if (k == d) begin
          cyc();
          bus.wr_rsp_valid = 1'b0;
          #1;
          chk1("done_pulse", bus.done, 1'b1);
          chk1("req_ready_with_done", bus.req_ready, 1'b0);
          cyc();
          #1;
          chk1("done_clear", bus.done, 1'b0);
          chk1("req_ready_after_done", bus.req_ready, 1'b1);
          chk1("error_after_done", bus.error, v.exp_err);
          mseq = next_seq(mseq);
          return;
        end
      end
      cyc();
      bus.wr_rsp_valid = 1'b0;
    end
    #1;
    chk1("error_on_second_timeout", bus.error, v.exp_err);
    chk1("req_ready_after_error", bus.req_ready, 1'b1);
    chk1("done_after_error", bus.done, 1'b0);
    merr = 1'b1;
  endtask
  initial begin
    vec_t v;
    bus.req_valid = 1'b0;
    bus.req_code = STATUS_IDLE;
    bus.req_cls_sent = '0;
    bus.status_addr = '0;
    bus.c1_alm_full = 1'b0;
    bus.wr_rsp_valid = 1'b0;
    bus.wr_rsp_mdata = '0;
    tbl[0] = '{3, 32'd42, 42'h100, 0, 2, -1, -1, 1, 1'b0};
    tbl[1] = '{1, 32'd7, 42'h2000, 20, 0, -1, -1, 2, 1'b0};
    tbl[2] = '{2, 32'd1000, 42'h3_ffff_ffff, 0, 6, -1, 2, 3, 1'b0};
    tbl[3] = '{0, 32'hffff_ffff, 42'h3ff_ffff_ffff, 1, 15, -1, 14, 4, 1'b0};
    tbl[4] = '{3, 32'd5, 42'h40, 0, -1, 4, 15, 5, 1'b0};
    tbl[5] = '{2, 32'd9, 42'h80, 2, -1, -1, 3, 6, 1'b1};
    tbl[6] = '{3, 32'd11, 42'h80, 0, 1, -1, -1, 6, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_req_ready", bus.req_ready, 1'b0);
    chk1("reset_wr_valid", bus.wr_valid, 1'b0);
    chk1("reset_done", bus.done, 1'b0);
    chk1("reset_error", bus.error, 1'b0);
    chkw("reset_wr_addr", 512'(bus.wr_addr), '0);
    chkw("reset_wr_data", bus.wr_data, '0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) send(tbl[i]);
    cyc();
    bus.wr_rsp_valid = 1'b1;
    bus.wr_rsp_mdata = 16'd7;
    #1;
    cyc();
    bus.wr_rsp_valid = 1'b0;
    #1;
    chk1("stale_rsp_idle_done", bus.done, 1'b0);
    chk1("stale_rsp_idle_ready", bus.req_ready, 1'b1);
    for (int n = 0; n < 40; n++) begin
      v.code = $urandom_range(0, 3);
      v.cls = $urandom;
      v.addr = 42'({$urandom, $urandom});
      v.bp = $urandom_range(0, 4);
      v.d1 = $urandom_range(0, 9) < 8 ? int'($urandom_range(0, TMO - 1)) : -1;
      v.d2 = $urandom_range(0, 3) != 0 ? int'($urandom_range(0, TMO - 1)) : -1;
      v.fk = $urandom_range(0, 1) != 0 ? int'($urandom_range(0, TMO - 1)) : -1;
      v.exp_seq = mseq;
      v.exp_err = merr || (v.d1 < 0 && v.d2 < 0);
      send(v);
    end
    cyc();
    bus.req_valid = 1'b1;
    bus.req_code = STATUS_DONE;
    bus.req_cls_sent = 32'd77;
    bus.status_addr = 42'h500;
    bus.c1_alm_full = 1'b0;
    #1;
    cyc();
    bus.req_valid = 1'b0;
    #1;
    chk1("rst_seq_issue", bus.wr_valid, 1'b1);
    repeat (3) cyc();
    reset = 1'b1;
    #1;
    chk1("async_rst_wr_valid", bus.wr_valid, 1'b0);
    chk1("async_rst_done", bus.done, 1'b0);
    chk1("async_rst_req_ready", bus.req_ready, 1'b0);
    chk1("async_rst_error", bus.error, 1'b0);
    chkw("async_rst_wr_addr", 512'(bus.wr_addr), '0);
    chkw("async_rst_wr_data", bus.wr_data, '0);
    cyc();
    reset = 1'b0;
    bus.wr_rsp_valid = 1'b1;
    bus.wr_rsp_mdata = 16'd7;
    #1;
    cyc();
    bus.wr_rsp_valid = 1'b0;
    #1;
    chk1("late_rsp_after_reset_done", bus.done, 1'b0);
    chk1("late_rsp_after_reset_ready", bus.req_ready, 1'b1);
    mseq = 1;
    merr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      v = '{i % 4, 32'(i), 42'(i * 64), 0, 0, -1, -1, (i < 255 ? i + 1 : 1), 1'b0};
      send(v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/status_wr_engine.md
Name: status_wr_engine

Overview:
- Transmit-side counterpart of the CPU control-word path. It sends a status cache line (status code, cache lines sent, sequence nonce) to a CPU-visible status buffer over the CCI write channel (c1).
- It waits for the write response, then reports completion to the AFU state machine.
- The CPU polls the status buffer. It uses the nonce byte to tell a fresh status from a stale one, exactly as the AFU does for control words.

Parameters:
- WRITE_STATUS_MDATA, 16'd7, mdata tag on status writes; must differ from READ_CTRL_MDATA and READ_RUN_MDATA.
- RSP_TIMEOUT, 1024, cycles to wait for a write response before one reissue.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- status_addr  input  t_cci_clAddr (42)  cache-line address of the status buffer; sampled on accept
- req_valid  input  1  request to send a status line
- req_ready  output  1  engine can accept a request (state IDLE)
- req_code  input  e_status_code (3)  status code to report
- req_cls_sent  input  t_uint32  run cache lines sent
- c1_alm_full  input  1  write channel almost-full
- wr_valid  output  1  write request strobe
- wr_addr  output  t_cci_clAddr  write address
- wr_data  output  t_cci_clData (512)  status cache line
- wr_mdata  output  16  always WRITE_STATUS_MDATA
- wr_rsp_valid  input  1  c1 write response valid
- wr_rsp_mdata  input  16  response mdata
- done  output  1  one-cycle pulse when the write is acknowledged
- error  output  1  sticky; set when a timeout occurs on the reissued write

Behaviour:
- Reset (async, active-high): state=IDLE, req_ready=0 during reset, wr_valid=0, wr_addr=0, wr_data=0, done=0, error=0, seq=8'd1, timer=0.
- Status line layout:
  - u64[0] = code, zero-extended.
  - u64[1] = cls_sent, zero-extended.
  - u64[2..6] = 0.
  - u64[7][63:56] = seq; remaining bits 0.
  - This equals constructStatusCL with the nonce byte added.
- States:
  - IDLE: req_ready=1. On req_valid, latch code, cls_sent, status_addr and the current seq, then go to ISSUE.
  - ISSUE: if !c1_alm_full, assert wr_valid for exactly 1 cycle with the latched fields, clear timer, go to WAIT_RSP. If alm_full is set, hold in ISSUE with wr_valid=0.
  - WAIT_RSP: timer increments each cycle.
    - On wr_rsp_valid && wr_rsp_mdata==WRITE_STATUS_MDATA: done=1 next cycle, increment seq, go to IDLE.
    - If timer reaches RSP_TIMEOUT-1 and this is the first attempt: go to ISSUE to reissue with the same seq.
    - If the timeout occurs on the second attempt: set error, go to IDLE without incrementing seq.
- Latency:
  - Accept to wr_valid is 1 cycle minimum (accept cycle N, wr_valid N+1).
  - Response to done is 1 cycle.
  - req_ready returns the cycle after done.
- seq wraps from 255 to 1 and never takes 0, because the CPU zeroes the buffer and 0 means "no status".
- Responses with any other mdata are ignored in all states. A matching response in IDLE or ISSUE is a stale duplicate from the timeout path and is ignored.
- req_valid while not IDLE is not accepted; the requester holds its request. Inputs are not re-sampled until the next accept.
- Response in the same cycle as the timeout terminal count: the response wins (done, no reissue).
- Reset mid-operation: an outstanding request is dropped, and a later response is ignored because the state is IDLE. The CPU sees the seq restart at 1.

Decomposition:
- Add WRITE_STATUS_MDATA, the e_status_wr_state enum (IDLE, ISSUE, WAIT_RSP) and a function constructStatusCLSeq(code, cls_sent, seq) to the interface_debug package.
- The optional sub-module status_seq_counter is an 8-bit counter with the 255->1 skip-zero wrap. It is small enough to stay inline.
- No other sub-module is needed.

Test Plan:
- Basic send: status_addr=0x100, code=STATUS_DONE, cls=42, alm_full=0. Expect wr_valid one cycle later with addr=0x100, u64[0]=3, u64[1]=42, byte63=1. A response with mdata 7 gives done one cycle later, and req_ready=1.
- Back-pressure: alm_full=1 for 20 cycles after accept. Expect no wr_valid for 20 cycles, then exactly one wr_valid the cycle alm_full drops.
- Seq wrap: 256 back-to-back completed sends. Expect byte63 sequence 1..255 then 1, never 0.
- Foreign response: wr_rsp_valid with mdata 5 during WAIT_RSP. Expect no done; the later mdata 7 response gives done.
- Timeout: RSP_TIMEOUT=16, no response. Expect a reissue at cycle 16 with the same seq. No response again gives error=1, IDLE, and the next send reuses the same seq.
- Async reset in WAIT_RSP: assert reset between clocks. Outputs clear immediately; a late mdata 7 response produces no done.
